// File: rtl/main_control_if.sv
// rtl/main_control_if.sv - control bundle between the TinyMIPS main FSM and its datapath
interface main_control_if;
    logic [5:0] op;
    logic       zero;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic [3:0] irwrite;
    logic       pcen;
    logic [1:0] pcsource;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal_op;
    logic [3:0] state;

    // Datapath side: supplies opcode and zero flag, consumes control strobes
    modport master (
        output op, zero,
        input  memread, memwrite, iord, irwrite, pcen, pcsource, alusrca, alusrcb,
               aluop, regwrite, regdst, memtoreg, illegal_op, state
    );

    // Controller side
    modport slave (
        input  op, zero,
        output memread, memwrite, iord, irwrite, pcen, pcsource, alusrca, alusrcb,
               aluop, regwrite, regdst, memtoreg, illegal_op, state
    );
endinterface

// File: rtl/main_control.sv
// rtl/main_control.sv - multicycle main control FSM for the 8-bit TinyMIPS datapath
module main_control (
    input  logic          clk,
    input  logic          reset_n,
    main_control_if.slave ctl
);
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,  S_FETCH2  = 4'd1,  S_FETCH3  = 4'd2,  S_FETCH4 = 4'd3,
        S_DECODE  = 4'd4,  S_MEMADR  = 4'd5,  S_LBRD    = 4'd6,  S_LBWR   = 4'd7,
        S_SBWR    = 4'd8,  S_RTYPEEX = 4'd9,  S_RTYPEWR = 4'd10, S_BEQEX  = 4'd11,
        S_JEX     = 4'd12, S_ADDIEX  = 4'd13, S_ADDIWR  = 4'd14
    } state_t;

    state_t state_q, state_d;
    logic   pcwrite, pcwritecond;

    // Next-state selection; op only matters in DECODE and MEMADR, code 15 recovers to FETCH1
    always_comb begin
        state_d = S_FETCH1;
        case (state_q)
            S_FETCH1:  state_d = S_FETCH2;
            S_FETCH2:  state_d = S_FETCH3;
            S_FETCH3:  state_d = S_FETCH4;
            S_FETCH4:  state_d = S_DECODE;
            S_DECODE: begin
                case (ctl.op)
                    OP_LB, OP_SB: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH1;
                endcase
            end
            S_MEMADR:  state_d = (ctl.op == OP_LB) ? S_LBRD : S_SBWR;
            S_LBRD:    state_d = S_LBWR;
            S_RTYPEEX: state_d = S_RTYPEWR;
            S_ADDIEX:  state_d = S_ADDIWR;
            default:   state_d = S_FETCH1;
        endcase
    end

    // State register, held at FETCH1 while reset is asserted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode; everything is gated off while reset is low so no write can complete
    always_comb begin
        ctl.memread    = 1'b0;
        ctl.memwrite   = 1'b0;
        ctl.iord       = 1'b0;
        ctl.irwrite    = 4'b0000;
        ctl.pcsource   = 2'b00;
        ctl.alusrca    = 1'b0;
        ctl.alusrcb    = 2'b00;
        ctl.aluop      = 2'b00;
        ctl.regwrite   = 1'b0;
        ctl.regdst     = 1'b0;
        ctl.memtoreg   = 1'b0;
        ctl.illegal_op = 1'b0;
        pcwrite        = 1'b0;
        pcwritecond    = 1'b0;
        if (reset_n) begin
            case (state_q)
                S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                    ctl.memread = 1'b1;
                    ctl.irwrite = 4'b0001 << state_q[1:0];
                    ctl.alusrcb = 2'b01;
                    pcwrite     = 1'b1;
                end
                S_DECODE: begin
                    ctl.alusrcb = 2'b11;
                    case (ctl.op)
                        OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: ctl.illegal_op = 1'b0;
                        default:                                       ctl.illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    ctl.alusrca = 1'b1;
                    ctl.alusrcb = 2'b10;
                end
                S_LBRD: begin
                    ctl.memread = 1'b1;
                    ctl.iord    = 1'b1;
                end
                S_LBWR: begin
                    ctl.regwrite = 1'b1;
                    ctl.memtoreg = 1'b1;
                end
                S_SBWR: begin
                    ctl.memwrite = 1'b1;
                    ctl.iord     = 1'b1;
                end
                S_RTYPEEX: begin
                    ctl.alusrca = 1'b1;
                    ctl.aluop   = 2'b10;
                end
                S_RTYPEWR: begin
                    ctl.regwrite = 1'b1;
                    ctl.regdst   = 1'b1;
                end
                S_BEQEX: begin
                    ctl.alusrca  = 1'b1;
                    ctl.aluop    = 2'b01;
                    ctl.pcsource = 2'b01;
                    pcwritecond  = 1'b1;
                end
                S_JEX: begin
                    ctl.pcsource = 2'b10;
                    pcwrite      = 1'b1;
                end
                S_ADDIEX: begin
                    ctl.alusrca = 1'b1;
                    ctl.alusrcb = 2'b10;
                end
                S_ADDIWR: begin
                    ctl.regwrite = 1'b1;
                end
                default: begin
                    ctl.memread = 1'b0;
                end
            endcase
        end
    end

    assign ctl.pcen  = pcwrite | (pcwritecond & ctl.zero);
    assign ctl.state = state_q;
endmodule

// File: tb/tb_main_control.sv
// tb/tb_main_control.sv - directed table-driven bench for main_control
module tb_main_control;
    typedef struct {
        logic [5:0]  op;
        logic        zero;
        logic [3:0]  st;
        logic [18:0] outs;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   failed = 0;
    vec_t vecs[$];

    main_control_if bus ();

    main_control dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ctl     (bus)
    );

    always #5 clk = ~clk;

    logic [18:0] act;
    assign act = {bus.memread, bus.memwrite, bus.iord, bus.irwrite, bus.pcen, bus.pcsource,
                  bus.alusrca, bus.alusrcb, bus.aluop, bus.regwrite, bus.regdst,
                  bus.memtoreg, bus.illegal_op};

    function automatic logic [18:0] w(input logic mr, input logic mw, input logic io,
                                      input logic [3:0] irw, input logic pe, input logic [1:0] ps,
                                      input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                      input logic rw, input logic rd, input logic mtr,
                                      input logic ill);
        return {mr, mw, io, irw, pe, ps, asa, asb, aop, rw, rd, mtr, ill};
    endfunction

    task automatic check(input string name, input logic [3:0] st_exp, input logic [18:0] o_exp);
        tests++;
        if (bus.state !== st_exp || act !== o_exp) begin
            failed++;
            $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     name, bus.state, act, st_exp, o_exp);
        end
    endtask

    task automatic add(input logic [5:0] o, input logic z, input logic [3:0] s, input logic [18:0] e);
        vec_t v;
        v.op = o; v.zero = z; v.st = s; v.outs = e;
        vecs.push_back(v);
    endtask

    logic [18:0] e_f[4];
    logic [18:0] e_dec, e_ill, e_memadr, e_lbrd, e_lbwr, e_sbwr, e_rtex, e_rtwr;
    logic [18:0] e_beq1, e_beq0, e_jex, e_addiex, e_addiwr, e_zero;

    task automatic add_fetch(input logic [5:0] junk);
        for (int n = 0; n < 4; n++) add(junk, 1'b0, 4'(n), e_f[n]);
    endtask

    initial begin
        e_f[0]   = w(1,0,0,4'b0001,1,2'b00,0,2'b01,2'b00,0,0,0,0);
        e_f[1]   = w(1,0,0,4'b0010,1,2'b00,0,2'b01,2'b00,0,0,0,0);
        e_f[2]   = w(1,0,0,4'b0100,1,2'b00,0,2'b01,2'b00,0,0,0,0);
        e_f[3]   = w(1,0,0,4'b1000,1,2'b00,0,2'b01,2'b00,0,0,0,0);
        e_dec    = w(0,0,0,4'b0000,0,2'b00,0,2'b11,2'b00,0,0,0,0);
        e_ill    = w(0,0,0,4'b0000,0,2'b00,0,2'b11,2'b00,0,0,0,1);
        e_memadr = w(0,0,0,4'b0000,0,2'b00,1,2'b10,2'b00,0,0,0,0);
        e_lbrd   = w(1,0,1,4'b0000,0,2'b00,0,2'b00,2'b00,0,0,0,0);
        e_lbwr   = w(0,0,0,4'b0000,0,2'b00,0,2'b00,2'b00,1,0,1,0);
        e_sbwr   = w(0,1,1,4'b0000,0,2'b00,0,2'b00,2'b00,0,0,0,0);
        e_rtex   = w(0,0,0,4'b0000,0,2'b00,1,2'b00,2'b10,0,0,0,0);
        e_rtwr   = w(0,0,0,4'b0000,0,2'b00,0,2'b00,2'b00,1,1,0,0);
        e_beq1   = w(0,0,0,4'b0000,1,2'b01,1,2'b00,2'b01,0,0,0,0);
        e_beq0   = w(0,0,0,4'b0000,0,2'b01,1,2'b00,2'b01,0,0,0,0);
        e_jex    = w(0,0,0,4'b0000,1,2'b10,0,2'b00,2'b00,0,0,0,0);
        e_addiex = w(0,0,0,4'b0000,0,2'b00,1,2'b10,2'b00,0,0,0,0);
        e_addiwr = w(0,0,0,4'b0000,0,2'b00,0,2'b00,2'b00,1,0,0,0);
        e_zero   = '0;

        // RTYPE: 0,1,2,3,4,9,10
        add_fetch(6'b111111);
        add(6'b000000, 0, 4,  e_dec);
        add(6'b000000, 0, 9,  e_rtex);
        add(6'b100000, 0, 10, e_rtwr);
        // BEQ taken
        add_fetch(6'b111011);
        add(6'b000100, 1, 4,  e_dec);
        add(6'b000100, 1, 11, e_beq1);
        // BEQ not taken
        add_fetch(6'b111011);
        add(6'b000100, 0, 4,  e_dec);
        add(6'b000100, 0, 11, e_beq0);
        // LB
        add_fetch(6'b011111);
        add(6'b100000, 0, 4,  e_dec);
        add(6'b100000, 0, 5,  e_memadr);
        add(6'b101000, 0, 6,  e_lbrd);
        add(6'b000000, 0, 7,  e_lbwr);
        // SB
        add_fetch(6'b010111);
        add(6'b101000, 0, 4,  e_dec);
        add(6'b101000, 0, 5,  e_memadr);
        add(6'b100000, 0, 8,  e_sbwr);
        // J
        add_fetch(6'b111101);
        add(6'b000010, 0, 4,  e_dec);
        add(6'b000010, 1, 12, e_jex);
        // ADDI
        add_fetch(6'b110111);
        add(6'b001000, 0, 4,  e_dec);
        add(6'b001000, 0, 13, e_addiex);
        add(6'b001000, 0, 14, e_addiwr);
        // illegal opcode
        add_fetch(6'b000000);
        add(6'b111111, 0, 4,  e_ill);
        add(6'b000000, 0, 0,  e_f[0]);

        // Reset held for three cycles: everything low
        bus.op = 6'b000000;
        bus.zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            check("reset_hold", 4'd0, e_zero);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus.op = vecs[i].op;
            bus.zero = vecs[i].zero;
            #2;
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].outs);
        end

        // Reset asserted in RTYPEWR: regwrite must drop immediately
        bus.op = 6'b000000;
        bus.zero = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        check("rtwr_before_reset", 4'd10, e_rtwr);
        reset_n = 1'b0;
        #1;
        check("rtwr_reset_immediate", 4'd0, e_zero);
        @(posedge clk);
        #1;
        check("reset_held_posedge", 4'd0, e_zero);
        reset_n = 1'b1;
        @(negedge clk);
        #2;
        check("restart_fetch1", 4'd0, e_f[0]);
        @(negedge clk);
        #2;
        check("restart_fetch2", 4'd1, e_f[1]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
